// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the regfile writeback arbiter.
// Provides the `CLOG2 helper macro and default sizing constants.
// Optional feature macro: RF_WB_SCOREBOARD_EN (see regfile_wb_arbiter.sv).

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package regfile_wb_arbiter_pkg;

  localparam int unsigned DefRegWidth = 32;
  localparam int unsigned DefNumRegs  = 32;
  localparam int unsigned DefNumReq   = 3;

  // True when a write to this index must be dropped because r0 reads as zero.
  function automatic logic is_zero_reg(input logic r0_is_zero, input logic [31:0] idx);
    return r0_is_zero && (idx == 32'd0);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: starting at Ptr_i, grants the first valid requester
// (wrapping modulo N). Purely combinational; reusable for bus arbitration.

module regfile_wb_arbiter_rr_arbiter #(
  parameter int N = 3,
  localparam int IdxW = `CLOG2(N)
) (
  input  logic [N-1:0]    Valid_i,
  input  logic [IdxW-1:0] Ptr_i,
  output logic [N-1:0]    Grant_o,
  output logic [IdxW-1:0] Grant_Idx_o,
  output logic            Any_o
);

  // Scan ptr, ptr+1, ... and stop at the first valid requester.
  always_comb begin
    int j;
    Grant_o     = '0;
    Grant_Idx_o = '0;
    Any_o       = 1'b0;
    j           = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(Ptr_i) + i;
      if (j >= N) j = j - N;
      if (!Any_o && Valid_i[IdxW'(j)]) begin
        Any_o               = 1'b1;
        Grant_o[IdxW'(j)]   = 1'b1;
        Grant_Idx_o         = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile writeback arbiter: shares the single regfile write port among
// NUM_REQ writeback sources with round-robin priority and a registered
// write stage (one write per cycle).
// Optional feature macro: RF_WB_SCOREBOARD_EN enables the pending-destination
// scoreboard; when undefined Pending_o is tied low and Sb_Set_* are ignored.

module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = DefRegWidth,
  parameter int unsigned NUM_REGS   = DefNumRegs,
  parameter int unsigned NUM_REQ    = DefNumReq,
  parameter bit          R0_IS_ZERO = 1'b1,
  localparam int unsigned SELW      = `CLOG2(NUM_REGS),
  localparam int unsigned IDXW      = `CLOG2(NUM_REQ)
) (
  input  logic                           Clk_i,
  input  logic                           Rst_i,
  input  logic [NUM_REQ-1:0]             Req_Valid_i,
  output logic [NUM_REQ-1:0]             Req_Ready_o,
  input  logic [NUM_REQ*SELW-1:0]        Req_Rd_Sel_i,
  input  logic [NUM_REQ*REG_WIDTH-1:0]   Req_Data_i,
  output logic                           Data_We_o,
  output logic [SELW-1:0]                Rd_Sel_o,
  output logic [REG_WIDTH-1:0]           Data_o,
  input  logic                           Sb_Set_i,
  input  logic [SELW-1:0]                Sb_Set_Sel_i,
  output logic [NUM_REGS-1:0]            Pending_o
);

  logic [SELW-1:0]      rd_arr   [NUM_REQ];
  logic [REG_WIDTH-1:0] data_arr [NUM_REQ];

  logic [NUM_REQ-1:0]   grant;
  logic [IDXW-1:0]      grant_idx;
  logic                 grant_any;
  logic [SELW-1:0]      gnt_rd;
  logic [REG_WIDTH-1:0] gnt_data;
  logic                 gnt_drop;

  logic [IDXW-1:0]      ptr_q, ptr_d;
  logic                 we_q, we_d;
  logic [SELW-1:0]      rd_q, rd_d;
  logic [REG_WIDTH-1:0] data_q, data_d;

  // Unpack the flat request buses into per-requester fields.
  always_comb begin
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      rd_arr[k]   = Req_Rd_Sel_i[k*SELW +: SELW];
      data_arr[k] = Req_Data_i[k*REG_WIDTH +: REG_WIDTH];
    end
  end

  regfile_wb_arbiter_rr_arbiter #(
    .N (int'(NUM_REQ))
  ) u_rr_arbiter (
    .Valid_i     (Req_Valid_i),
    .Ptr_i       (ptr_q),
    .Grant_o     (grant),
    .Grant_Idx_o (grant_idx),
    .Any_o       (grant_any)
  );

  assign Req_Ready_o = grant;
  assign gnt_rd      = rd_arr[grant_idx];
  assign gnt_data    = data_arr[grant_idx];
  // r0 writes are still handshaken; only the regfile enable is suppressed.
  assign gnt_drop    = is_zero_reg(R0_IS_ZERO, 32'(gnt_rd));

  // Next-state for the priority pointer and the registered write stage.
  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (grant_any) begin
      ptr_d  = (grant_idx == IDXW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      we_d   = !gnt_drop;
      rd_d   = gnt_rd;
      data_d = gnt_data;
    end
  end

  // Pointer and write-stage registers; reset drops any in-flight write.
  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign Data_We_o = we_q;
  assign Rd_Sel_o  = rd_q;
  assign Data_o    = data_q;

`ifdef RF_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                sb_set_ok;

  assign sb_set_ok = Sb_Set_i && !is_zero_reg(R0_IS_ZERO, 32'(Sb_Set_Sel_i));

  // Clear on grant, then set; a same-cycle set belongs to a newer producer.
  always_comb begin
    pending_d = pending_q;
    if (grant_any) pending_d[gnt_rd] = 1'b0;
    if (sb_set_ok) pending_d[Sb_Set_Sel_i] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign Pending_o = pending_q;
`else
  logic unused_sb;
  assign unused_sb = ^{Sb_Set_i, Sb_Set_Sel_i};
  assign Pending_o = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.

module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int NREG = 32;
  localparam int SELW = 5;
  localparam int W    = 32;

  logic                 Clk_i = 1'b0;
  logic                 Rst_i = 1'b0;
  logic [NREQ-1:0]      Req_Valid_i;
  logic [NREQ-1:0]      Req_Ready_o;
  logic [NREQ*SELW-1:0] Req_Rd_Sel_i;
  logic [NREQ*W-1:0]    Req_Data_i;
  logic                 Data_We_o;
  logic [SELW-1:0]      Rd_Sel_o;
  logic [W-1:0]         Data_o;
  logic                 Sb_Set_i = 1'b0;
  logic [SELW-1:0]      Sb_Set_Sel_i = '0;
  logic [NREG-1:0]      Pending_o;

  regfile_wb_arbiter dut (
    .Clk_i        (Clk_i),
    .Rst_i        (Rst_i),
    .Req_Valid_i  (Req_Valid_i),
    .Req_Ready_o  (Req_Ready_o),
    .Req_Rd_Sel_i (Req_Rd_Sel_i),
    .Req_Data_i   (Req_Data_i),
    .Data_We_o    (Data_We_o),
    .Rd_Sel_o     (Rd_Sel_o),
    .Data_o       (Data_o),
    .Sb_Set_i     (Sb_Set_i),
    .Sb_Set_Sel_i (Sb_Set_Sel_i),
    .Pending_o    (Pending_o)
  );

  always #5 Clk_i = ~Clk_i;

  // Requester-side stimulus state.
  logic            v  [NREQ] = '{default: 1'b0};
  logic [SELW-1:0] rs [NREQ] = '{default: '0};
  logic [W-1:0]    ds [NREQ] = '{default: '0};

  always_comb begin
    Req_Valid_i  = '0;
    Req_Rd_Sel_i = '0;
    Req_Data_i   = '0;
    for (int k = 0; k < NREQ; k++) begin
      Req_Valid_i[k]              = v[k];
      Req_Rd_Sel_i[k*SELW +: SELW] = rs[k];
      Req_Data_i[k*W +: W]        = ds[k];
    end
  end

  // Register file fed by the DUT write port.
  logic [W-1:0] rf_dut [NREG] = '{default: '0};
  always @(posedge Clk_i) if (Data_We_o) rf_dut[Rd_Sel_o] <= Data_o;

  // Behavioural model.
  int           ptr_m;
  logic         we_m;
  logic [SELW-1:0] rd_m;
  logic [W-1:0] data_m;
  logic [NREG-1:0] pend_m;
  int           wait_m [NREQ];
  logic [W-1:0] rf_m [NREG] = '{default: '0};

  function automatic int model_grant();
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (ptr_m + i) % NREQ;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [NREG-1:0] pend_next();
    logic [NREG-1:0] p;
    int g;
    p = pend_m;
`ifdef RF_WB_SCOREBOARD_EN
    g = model_grant();
    if (g >= 0) p[rs[g]] = 1'b0;
    if (Sb_Set_i && Sb_Set_Sel_i != 0) p[Sb_Set_Sel_i] = 1'b1;
`else
    g = 0;
    p = '0;
`endif
    return p;
  endfunction

  always @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      ptr_m  <= 0;
      we_m   <= 1'b0;
      rd_m   <= '0;
      data_m <= '0;
      pend_m <= '0;
      for (int k = 0; k < NREQ; k++) wait_m[k] <= 0;
    end else begin
      if (we_m) rf_m[rd_m] <= data_m;
      pend_m <= pend_next();
      if (model_grant() >= 0) begin
        we_m   <= (rs[model_grant()] != 0);
        rd_m   <= rs[model_grant()];
        data_m <= ds[model_grant()];
        ptr_m  <= (model_grant() + 1) % NREQ;
      end else begin
        we_m <= 1'b0;
      end
      for (int k = 0; k < NREQ; k++)
        wait_m[k] <= (v[k] && model_grant() != k) ? wait_m[k] + 1 : 0;
    end
  end

  int vectors = 0;
  int errors  = 0;
  int last_g  = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: compare against the model mid-cycle, then advance past the edge.
  task automatic tick();
    @(negedge Clk_i);
    last_g = model_grant();
    chk("ready", 64'(Req_Ready_o), (last_g >= 0) ? 64'(1) << last_g : 64'd0);
    chk("we", 64'(Data_We_o), 64'(we_m));
    if (we_m) begin
      chk("rd", 64'(Rd_Sel_o), 64'(rd_m));
      chk("data", 64'(Data_o), 64'(data_m));
    end
    chk("pending", 64'(Pending_o), 64'(pend_m));
    for (int k = 0; k < NREQ; k++) chk("starve", 64'(wait_m[k] < NREQ), 64'd1);
    @(posedge Clk_i);
    #1;
  endtask

  initial begin
    int exp_g [6] = '{0, 1, 2, 0, 1, 2};

    // Reset state.
    repeat (2) @(posedge Clk_i);
    #1;
    chk("rst_we", 64'(Data_We_o), 64'd0);
    chk("rst_rd", 64'(Rd_Sel_o), 64'd0);
    chk("rst_data", 64'(Data_o), 64'd0);
    chk("rst_pend", 64'(Pending_o), 64'd0);
    Rst_i = 1'b1;

    // Reset asserted while req0 is being granted: the write is lost.
    @(posedge Clk_i); #1;
    v[0] = 1'b1; rs[0] = 5'd5; ds[0] = 32'hAAAA_5555;
    #2 Rst_i = 1'b0;
    #1;
    chk("rstmid_we", 64'(Data_We_o), 64'd0);
    @(posedge Clk_i); #1;
    chk("rstmid_we2", 64'(Data_We_o), 64'd0);
    chk("rstmid_pend", 64'(Pending_o), 64'd0);
    v[0] = 1'b0;
    Rst_i = 1'b1;
    @(posedge Clk_i); #1;
    chk("rstmid_rf5", 64'(rf_dut[5]), 64'd0);

    // Single request from req1.
    v[1] = 1'b1; rs[1] = 5'd7; ds[1] = 32'hDEAD_BEEF;
    #1 chk("single_ready", 64'(Req_Ready_o), 64'b010);
    tick();
    v[1] = 1'b0;
    chk("single_we", 64'(Data_We_o), 64'd1);
    chk("single_rd", 64'(Rd_Sel_o), 64'd7);
    chk("single_data", 64'(Data_o), 64'hDEAD_BEEF);
    tick();
    chk("single_we_off", 64'(Data_We_o), 64'd0);

    // Write to r0 from req2 is accepted but discarded.
    v[2] = 1'b1; rs[2] = 5'd0; ds[2] = 32'h1234;
    #1 chk("r0_ready", 64'(Req_Ready_o), 64'b100);
    tick();
    v[2] = 1'b0;
    chk("r0_we", 64'(Data_We_o), 64'd0);

    // All three valid: strict rotation starting at req0.
    for (int k = 0; k < NREQ; k++) begin
      v[k] = 1'b1; rs[k] = 5'(10 + k); ds[k] = 32'(100 + k);
    end
    for (int c = 0; c < 6; c++) begin
      #1 chk("rr_ready", 64'(Req_Ready_o), 64'(1) << exp_g[c]);
      tick();
      chk("rr_we", 64'(Data_We_o), 64'd1);
      chk("rr_rd", 64'(Rd_Sel_o), 64'(10 + exp_g[c]));
      ds[exp_g[c]] = 32'(200 + c);
    end
    for (int k = 0; k < NREQ; k++) v[k] = 1'b0;

    // Scoreboard set / set-vs-clear / clear.
    Sb_Set_i = 1'b1; Sb_Set_Sel_i = 5'd9;
    tick();
    Sb_Set_i = 1'b0;
`ifdef RF_WB_SCOREBOARD_EN
    chk("sb_set", 64'(Pending_o[9]), 64'd1);
`else
    chk("sb_off", 64'(Pending_o), 64'd0);
`endif
    Sb_Set_i = 1'b1; v[0] = 1'b1; rs[0] = 5'd9; ds[0] = 32'h99;
    #1 chk("sb_ready", 64'(Req_Ready_o), 64'b001);
    tick();
    Sb_Set_i = 1'b0;
`ifdef RF_WB_SCOREBOARD_EN
    chk("sb_setwins", 64'(Pending_o[9]), 64'd1);
`else
    chk("sb_off2", 64'(Pending_o), 64'd0);
`endif
    tick();
    v[0] = 1'b0;
    chk("sb_clear", 64'(Pending_o[9]), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (last_g == k) v[k] = 1'b0;
        if (!v[k] && ($urandom_range(0, 9) < 5)) begin
          v[k]  = 1'b1;
          rs[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
          ds[k] = $urandom;
        end
      end
      Sb_Set_i     = ($urandom_range(0, 9) < 3);
      Sb_Set_Sel_i = 5'($urandom);
      tick();
    end

    // Drain and compare register file contents.
    for (int k = 0; k < NREQ; k++) v[k] = 1'b0;
    Sb_Set_i = 1'b0;
    repeat (3) tick();
    for (int r = 0; r < NREG; r++) chk("regfile", 64'(rf_dut[r]), 64'(rf_m[r]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
